regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//  Integer register file: write side consumes the EX-stage result triple (rdE, rdIdx, rdData).
//  Serves two combinational read ports to ID.
//  Holds a per-register pending-write scoreboard so ID stalls on RAW hazards until the producing result is written.
//  x0 reads zero and is never written or marked pending.
// PARAMETERS
//  DATA_W   32  register width
//  REG_NUM  32  number of architectural registers
//  IDX_W    5   register index width, log2(REG_NUM)
//  PEND_W   2   pending-write counter width per register; max in-flight writes per reg = 2**PEND_W-1
// PORTS
//  clk_in        in   1       clock; all state updates on the rising edge
//  rst_in        in   1       reset, asynchronous, active-high
//  rdE_in        in   1       write enable from EX result path
//  rdIdx_in      in   IDX_W   write index
//  rdData_in     in   DATA_W  write data
//  rs1E_in       in   1       read port 1 enable
//  rs1Idx_in     in   IDX_W   read port 1 index
//  rs2E_in       in   1       read port 2 enable
//  rs2Idx_in     in   IDX_W   read port 2 index
//  issueE_in     in   1       ID issues an instruction that writes issueIdx_in
//  issueIdx_in   in   IDX_W   destination of the issuing instruction
//  flush_in      in   1       pipeline flush: clear all pending counters
//  rs1Data_out   out  DATA_W  read data 1 (0 when rs1E_in=0 or idx=0)
//  rs2Data_out   out  DATA_W  read data 2 (0 when rs2E_in=0 or idx=0)
//  stall_out     out  1       ID must hold: RAW hazard or issue-target counter saturated
// BEHAVIOUR
//  Reset (rst_in=1, async): all registers := 0; all pending counters := 0.
//    While rst_in is high: rsXData_out=0, stall_out=0.
//  Write: on a clock edge with rdE_in=1 and rdIdx_in!=0, regs[rdIdx_in] := rdData_in.
//    Writes to x0 are dropped and do not touch the scoreboard.
//  Pending counter pend[i], per clock edge; cnt_dec = rdE_in && rdIdx_in==i && i!=0:
//    issue accepted (issueE_in && !stall_out && issueIdx_in==i && i!=0) and not cnt_dec: +1
//    cnt_dec and not issue accepted: -1, saturating at 0 (stray write is legal)
//    both, or neither: unchanged
//  flush_in=1: all pend := 0 on the edge; the same-cycle write still updates regs; the issue is discarded.
//  Busy: busy[i] = pend[i]!=0 (see CONFIGURATION for bypass refinement).
//  stall_out = (rs1E_in && rs1Idx_in!=0 && busy[rs1Idx_in])
//            | (rs2E_in && rs2Idx_in!=0 && busy[rs2Idx_in])
//            | (issueE_in && issueIdx_in!=0 && pend[issueIdx_in]=={PEND_W{1'b1}}).
//    stall_out is purely combinational; 0-cycle latency.
//  Reads are combinational; latency 0.
//  Pend-update priority: flush_in > simultaneous issue/write cancel > single increment/decrement.
//  Reset deasserted mid-cycle: state is held at 0 until the first clock edge after release.
// CONFIGURATION
//  `REGFILE_BYPASS_EN defined:
//    - read idx == rdIdx_in with rdE_in=1 and idx!=0 returns rdData_in in the same cycle;
//    - busy[i] = (pend[i] - cnt_dec) != 0, i.e. a write retiring the last pending result unblocks the read this cycle.
//  Not defined:
//    - reads return the stored (old) value;
//    - busy[i] = pend[i]!=0, so the dependent instruction stalls one extra cycle and reads after the write edge.
// STRUCTURE
//  Shared defines (defines.vh): dataRange, regIdxRange, rstEnable, ZERO32 (existing);
//    add regNum=32, pendRange=[PEND_W-1:0], regZeroIdx=5'd0.
//  One sub-module: regfile_scoreboard. Holds the pend[] array, the issue/write/flush update and the busy/saturation logic.
//    The top holds the data array, read muxing and bypass.
// TESTING
//  1. Reset: pulse rst_in between edges -> all reads return 0, stall_out=0 immediately (async).
//  2. Write x5=0xDEADBEEF, next cycle read rs1=5 -> 0xDEADBEEF; write x0=0x1234 -> rs2=0 reads 0.
//  3. Issue x7; next cycle rs1=7 -> stall_out=1; write x7=0x55 that cycle:
//     with BYPASS_EN stall_out=0 and rs1Data_out=0x55 in the same cycle;
//     without BYPASS_EN stall_out=1 this cycle, 0 the next, then reads 0x55.
//  4. Issue x3 three times (PEND_W=2) -> pend=3; a 4th issue to x3 -> stall_out=1, pend stays 3;
//     one write to x3 -> pend=2.
//  5. Same-cycle issue x9 and write x9 with pend[9]=1 -> pend stays 1, regs[9] updated.
//  6. pend[4]=2, pend[8]=1, flush_in=1 with issue x4 -> all pend=0, no stalls next cycle.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared widths, types and constants for the regfile_wb slice
package regfile_wb_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_NUM = 32;
    localparam int IDX_W   = 5;
    localparam int PEND_W  = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam idx_t  REG_ZERO_IDX = '0;
    localparam pend_t PEND_MAX     = '1;
    localparam data_t DATA_ZERO    = '0;

    function automatic logic is_live_idx(idx_t idx);
        return idx != REG_ZERO_IDX;
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// rtl/regfile_wb_if.sv - write-back, read-port and issue bus between ID/EX and the register file
interface regfile_wb_if;
    import regfile_wb_pkg::*;

    logic  rdE_in;
    idx_t  rdIdx_in;
    data_t rdData_in;
    logic  rs1E_in;
    idx_t  rs1Idx_in;
    logic  rs2E_in;
    idx_t  rs2Idx_in;
    logic  issueE_in;
    idx_t  issueIdx_in;
    logic  flush_in;
    data_t rs1Data_out;
    data_t rs2Data_out;
    logic  stall_out;

    modport master (
        output rdE_in, rdIdx_in, rdData_in,
        output rs1E_in, rs1Idx_in, rs2E_in, rs2Idx_in,
        output issueE_in, issueIdx_in, flush_in,
        input  rs1Data_out, rs2Data_out, stall_out
    );

    modport slave (
        input  rdE_in, rdIdx_in, rdData_in,
        input  rs1E_in, rs1Idx_in, rs2E_in, rs2Idx_in,
        input  issueE_in, issueIdx_in, flush_in,
        output rs1Data_out, rs2Data_out, stall_out
    );

endinterface

// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - per-register pending-write counters, busy and stall generation
// Optional: REGFILE_BYPASS_EN lets a retiring write clear busy in the same cycle.
module regfile_wb_scoreboard
    import regfile_wb_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_rdE,
    input  idx_t i_rdIdx,
    input  logic i_issueE,
    input  idx_t i_issueIdx,
    input  logic i_flush,
    input  logic i_rs1E,
    input  idx_t i_rs1Idx,
    input  logic i_rs2E,
    input  idx_t i_rs2Idx,
    output logic o_stall
);

    pend_t              r_pend [REG_NUM];
    logic [REG_NUM-1:0] w_dec;
    logic [REG_NUM-1:0] w_inc;
    logic [REG_NUM-1:0] w_busy;
    logic               w_sat;
    logic               w_raw;
    logic               w_stall;

    always_comb begin
        w_dec  = '0;
        w_busy = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_dec[i] = i_rdE && (i_rdIdx == idx_t'(i));
`ifdef REGFILE_BYPASS_EN
            // a write retiring the last outstanding result frees the register now
            w_busy[i] = r_pend[i] > pend_t'(w_dec[i]);
`else
            w_busy[i] = r_pend[i] != '0;
`endif
        end
    end

    always_comb begin
        w_raw   = (i_rs1E && is_live_idx(i_rs1Idx) && w_busy[i_rs1Idx])
                | (i_rs2E && is_live_idx(i_rs2Idx) && w_busy[i_rs2Idx]);
        w_sat   = i_issueE && is_live_idx(i_issueIdx) && (r_pend[i_issueIdx] == PEND_MAX);
        w_stall = w_raw | w_sat;
        o_stall = !rst_in && w_stall;
    end

    always_comb begin
        w_inc = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            w_inc[i] = i_issueE && !w_stall && (i_issueIdx == idx_t'(i));
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (i_flush) begin
                    r_pend[i] <= '0;
                end else if (w_inc[i] && !w_dec[i]) begin
                    r_pend[i] <= r_pend[i] + pend_t'(1);
                end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != '0)) begin
                    r_pend[i] <= r_pend[i] - pend_t'(1);
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - integer register file with write-back port, two read ports and RAW scoreboard
// Optional: REGFILE_BYPASS_EN forwards the same-cycle write data to the read ports.
module regfile_wb
    import regfile_wb_pkg::*;
(
    input  logic         clk_in,
    input  logic         rst_in,
    regfile_wb_if.slave  bus
);

    data_t r_regs [REG_NUM];
    logic  w_wr_live;
    data_t w_rs1_data;
    data_t w_rs2_data;

    assign w_wr_live = bus.rdE_in && is_live_idx(bus.rdIdx_in);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[bus.rdIdx_in] <= bus.rdData_in;
        end
    end

    function automatic data_t read_sel(logic en, idx_t idx, data_t stored,
                                       logic wr_live, idx_t wr_idx, data_t wr_data);
        data_t v;
        v = DATA_ZERO;
        if (en && is_live_idx(idx)) begin
`ifdef REGFILE_BYPASS_EN
            v = (wr_live && (wr_idx == idx)) ? wr_data : stored;
`else
            v = (wr_live && (wr_idx == idx)) ? stored : stored;
`endif
        end
        return v;
    endfunction

    always_comb begin
        w_rs1_data = read_sel(bus.rs1E_in, bus.rs1Idx_in, r_regs[bus.rs1Idx_in],
                              w_wr_live, bus.rdIdx_in, bus.rdData_in);
        w_rs2_data = read_sel(bus.rs2E_in, bus.rs2Idx_in, r_regs[bus.rs2Idx_in],
                              w_wr_live, bus.rdIdx_in, bus.rdData_in);
        bus.rs1Data_out = rst_in ? DATA_ZERO : w_rs1_data;
        bus.rs2Data_out = rst_in ? DATA_ZERO : w_rs2_data;
    end

    regfile_wb_scoreboard u_scoreboard (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_rdE      (bus.rdE_in),
        .i_rdIdx    (bus.rdIdx_in),
        .i_issueE   (bus.issueE_in),
        .i_issueIdx (bus.issueIdx_in),
        .i_flush    (bus.flush_in),
        .i_rs1E     (bus.rs1E_in),
        .i_rs1Idx   (bus.rs1Idx_in),
        .i_rs2E     (bus.rs2E_in),
        .i_rs2Idx   (bus.rs2Idx_in),
        .o_stall    (bus.stall_out)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - self-checking bench for regfile_wb with a cycle-level reference model
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_if bus ();

    regfile_wb dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    cmp_en   = 1'b0;
    data_t m_regs [REG_NUM];
    int    m_pend [REG_NUM];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(int i);
        int dec;
        dec = (bus.rdE_in && bus.rdIdx_in == idx_t'(i) && i != 0) ? 1 : 0;
`ifdef REGFILE_BYPASS_EN
        return (m_pend[i] - dec) > 0;
`else
        return m_pend[i] != 0;
`endif
    endfunction

    function automatic bit m_stall();
        bit s;
        if (rst) return 1'b0;
        s = 1'b0;
        if (bus.rs1E_in && bus.rs1Idx_in != 0 && m_busy(int'(bus.rs1Idx_in))) s = 1'b1;
        if (bus.rs2E_in && bus.rs2Idx_in != 0 && m_busy(int'(bus.rs2Idx_in))) s = 1'b1;
        if (bus.issueE_in && bus.issueIdx_in != 0 && m_pend[bus.issueIdx_in] == 3) s = 1'b1;
        return s;
    endfunction

    function automatic data_t m_read(bit en, idx_t idx);
        if (rst || !en || idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (bus.rdE_in && bus.rdIdx_in == idx) return bus.rdData_in;
`endif
        return m_regs[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 0;
            end
        end else begin
            bit acc;
            bit dec;
            acc = bus.issueE_in && !m_stall() && bus.issueIdx_in != 0;
            dec = bus.rdE_in && bus.rdIdx_in != 0;
            if (dec) m_regs[bus.rdIdx_in] = bus.rdData_in;
            if (bus.flush_in) begin
                for (int i = 0; i < REG_NUM; i++) m_pend[i] = 0;
            end else if (!(acc && dec && bus.issueIdx_in == bus.rdIdx_in)) begin
                if (acc) m_pend[bus.issueIdx_in] = m_pend[bus.issueIdx_in] + 1;
                if (dec && m_pend[bus.rdIdx_in] > 0) m_pend[bus.rdIdx_in] = m_pend[bus.rdIdx_in] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rs1", bus.rs1Data_out, m_read(bus.rs1E_in, bus.rs1Idx_in));
            check("cyc_rs2", bus.rs2Data_out, m_read(bus.rs2E_in, bus.rs2Idx_in));
            check("cyc_stall", 32'(bus.stall_out), 32'(m_stall()));
        end
    end

    task automatic idle();
        bus.rdE_in = 0; bus.rdIdx_in = '0; bus.rdData_in = '0;
        bus.rs1E_in = 0; bus.rs1Idx_in = '0; bus.rs2E_in = 0; bus.rs2Idx_in = '0;
        bus.issueE_in = 0; bus.issueIdx_in = '0; bus.flush_in = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(idx_t idx);
        bus.issueE_in = 1; bus.issueIdx_in = idx;
    endtask

    task automatic wr(idx_t idx, data_t d);
        bus.rdE_in = 1; bus.rdIdx_in = idx; bus.rdData_in = d;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.rs1E_in = 1; bus.rs1Idx_in = 5'd5;
        #1;
        check("rst_rs1", bus.rs1Data_out, 32'h0);
        check("rst_stall", 32'(bus.stall_out), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // write x5, read back; x0 write is dropped
        step(); wr(5'd5, 32'hDEADBEEF);
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd5; wr(5'd0, 32'h1234);
        #1; check("rd_x5", bus.rs1Data_out, 32'hDEADBEEF);
        step(); bus.rs2E_in = 1; bus.rs2Idx_in = 5'd0; bus.rs1Idx_in = 5'd5;
        #1; check("rd_x0", bus.rs2Data_out, 32'h0);
        check("rd_dis", bus.rs1Data_out, 32'h0);

        // asynchronous reset pulse between edges
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd5;
        #1; rst = 1'b1;
        #1; check("pulse_rs1", bus.rs1Data_out, 32'h0);
        check("pulse_stall", 32'(bus.stall_out), 32'h0);
        rst = 1'b0;
        #1; check("post_rs1", bus.rs1Data_out, 32'h0);

        // RAW on x7 resolved by a write
        step(); issue(5'd7);
        #1; check("iss7_stall", 32'(bus.stall_out), 32'h0);
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd7;
        #1; check("raw7_stall", 32'(bus.stall_out), 32'h1);
        wr(5'd7, 32'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp7_stall", 32'(bus.stall_out), 32'h0);
        check("byp7_data", bus.rs1Data_out, 32'h55);
`else
        check("nobyp7_stall", 32'(bus.stall_out), 32'h1);
        check("nobyp7_data", bus.rs1Data_out, 32'h0);
`endif
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd7;
        #1; check("after7_stall", 32'(bus.stall_out), 32'h0);
        check("after7_data", bus.rs1Data_out, 32'h55);

        // saturate x3 at three outstanding writes
        for (int k = 0; k < 3; k++) begin
            step(); issue(5'd3);
            #1; check("sat3_fill", 32'(bus.stall_out), 32'h0);
        end
        step(); issue(5'd3);
        #1; check("sat3_stall", 32'(bus.stall_out), 32'h1);
        step(); issue(5'd3);
        #1; check("sat3_hold", 32'(bus.stall_out), 32'h1);
        step(); wr(5'd3, 32'h33);
        step(); issue(5'd3);
        #1; check("sat3_room", 32'(bus.stall_out), 32'h0);
        step(); issue(5'd3);
        #1; check("sat3_again", 32'(bus.stall_out), 32'h1);

        // simultaneous issue and write on x9 cancel
        step(); issue(5'd9);
        step(); issue(5'd9); wr(5'd9, 32'h99);
        #1; check("x9_both_stall", 32'(bus.stall_out), 32'h0);
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd9;
        #1; check("x9_still_busy", 32'(bus.stall_out), 32'h1);
        check("x9_data", bus.rs1Data_out, 32'h99);
        step(); wr(5'd9, 32'h99);

        // flush clears every counter; same-cycle write still lands
        step(); issue(5'd4);
        step(); issue(5'd4);
        step(); issue(5'd8);
        step(); bus.flush_in = 1; issue(5'd4); wr(5'd12, 32'hABC);
        #1; check("flush_stall", 32'(bus.stall_out), 32'h0);
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd4; bus.rs2E_in = 1; bus.rs2Idx_in = 5'd8;
        #1; check("flush_nostall", 32'(bus.stall_out), 32'h0);
        step(); bus.rs1E_in = 1; bus.rs1Idx_in = 5'd3; bus.rs2E_in = 1; bus.rs2Idx_in = 5'd12;
        #1; check("flush_x3", 32'(bus.stall_out), 32'h0);
        check("flush_x12", bus.rs2Data_out, 32'hABC);

        step();
        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
